// File: rtl/instr_queue_mp.sv
// Multi-port circular instruction queue between fetch and decode.
// Accepts up to PUSH_W entries and retires up to POP_W entries per cycle. Overflowing pushes are clamped and flagged.
module instr_queue_mp #(
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned PUSH_W = 4,
    parameter  int unsigned POP_W  = 2,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PN_W   = $clog2(PUSH_W + 1),
    localparam int unsigned QN_W   = $clog2(POP_W + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [PUSH_W*DATA_W-1:0] push_data,
    input  logic [PN_W-1:0]          push_num,
    input  logic [QN_W-1:0]          pop_num,
    output logic [POP_W*DATA_W-1:0]  pop_data,
    output logic [POP_W-1:0]         pop_valid,
    output logic [CNT_W-1:0]         free_cnt,
    output logic [CNT_W-1:0]         count,
    output logic                     empty,
    output logic                     full,
    output logic                     push_ovf
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [CNT_W-1:0]  free_w;
    logic [CNT_W-1:0]  push_acc;
    logic [CNT_W-1:0]  pop_acc;

    always_comb begin
        free_w   = CNT_W'(DEPTH) - count_q;
        push_acc = (CNT_W'(push_num) > free_w) ? free_w : CNT_W'(push_num);
        pop_acc  = (CNT_W'(pop_num) > count_q) ? count_q : CNT_W'(pop_num);
        // Power-of-two depth: truncating the accepted count to PTR_W gives the modulo wrap.
        head_d   = head_q + PTR_W'(pop_acc);
        tail_d   = tail_q + PTR_W'(push_acc);
        count_d  = count_q + push_acc - pop_acc;
        ovf_d    = CNT_W'(push_num) > free_w;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is deliberately not reset; only accepted slots are written.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            for (int unsigned i = 0; i < PUSH_W; i++) begin
                if (CNT_W'(i) < push_acc) begin
                    mem_q[tail_q + PTR_W'(i)] <= push_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        pop_data  = '0;
        pop_valid = '0;
        for (int unsigned i = 0; i < POP_W; i++) begin
            pop_valid[i] = count_q > CNT_W'(i);
            if (pop_valid[i]) begin
                pop_data[i*DATA_W +: DATA_W] = mem_q[head_q + PTR_W'(i)];
            end
        end
    end

    assign free_cnt = free_w;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign push_ovf = ovf_q;

endmodule
